alu_issue_ctrl: RTL



---
 rtl/alu_issue_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// Four-state issue sequencer for an RV32I ADD/SUB/ADDI/BNE datapath.
// One instruction per 4 cycles: accept (IDLE) -> DECODE -> EXEC -> WB.
module alu_issue_ctrl #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              instr,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic                     EQ,
  output logic [ADDRESS_WIDTH-1:0] rs1,
  output logic [ADDRESS_WIDTH-1:0] rs2,
  output logic [ADDRESS_WIDTH-1:0] rd,
  output logic                     RegWrite,
  output logic                     ALUsrc,
  output logic                     ALUctrl,
  output logic [DATA_WIDTH-1:0]    immOp,
  output logic                     done,
  output logic                     br_taken,
  output logic [DATA_WIDTH-1:0]    br_offset,
  output logic                     illegal,
  output logic [CNT_WIDTH-1:0]     retired
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  state_t                state;
  logic                  wr_pend;
  logic                  bne_pend;

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic                  is_add, is_sub, is_addi, is_bne, legal;
  logic [DATA_WIDTH-1:0] imm_i, imm_b;

  // Decode straight from the input word so the DECODE-cycle outputs can be registered at the accept edge.
  always_comb begin
    opcode  = instr[6:0];
    funct3  = instr[14:12];
    funct7  = instr[31:25];
    is_add  = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
    is_sub  = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
    is_addi = (opcode == 7'b0010011) && (funct3 == 3'b000);
    is_bne  = (opcode == 7'b1100011) && (funct3 == 3'b001);
    legal   = is_add | is_sub | is_addi | is_bne;
    imm_i   = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
    imm_b   = {{(DATA_WIDTH-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      instr_ready <= 1'b1;
      rs1         <= '0;
      rs2         <= '0;
      rd          <= '0;
      RegWrite    <= 1'b0;
      ALUsrc      <= 1'b0;
      ALUctrl     <= 1'b0;
      immOp       <= '0;
      done        <= 1'b0;
      br_taken    <= 1'b0;
      br_offset   <= '0;
      illegal     <= 1'b0;
      retired     <= '0;
      wr_pend     <= 1'b0;
      bne_pend    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            state       <= DECODE;
            instr_ready <= 1'b0;
            rs1         <= ADDRESS_WIDTH'(instr[19:15]);
            rs2         <= ADDRESS_WIDTH'(instr[24:20]);
            rd          <= ADDRESS_WIDTH'(instr[11:7]);
            ALUsrc      <= is_addi;
            ALUctrl     <= is_sub | is_bne;
            immOp       <= is_addi ? imm_i : (is_bne ? imm_b : '0);
            illegal     <= ~legal;
            wr_pend     <= (is_add | is_sub | is_addi) && (instr[11:7] != 5'd0);
            bne_pend    <= is_bne;
          end
        end
        DECODE: begin
          illegal <= 1'b0;
          if (illegal) begin
            state       <= IDLE;
            instr_ready <= 1'b1;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          // EQ is captured here, at the end of the operand-settle cycle.
          state     <= WB;
          RegWrite  <= wr_pend;
          done      <= 1'b1;
          br_taken  <= bne_pend & ~EQ;
          br_offset <= bne_pend ? immOp : '0;
          retired   <= retired + CNT_WIDTH'(1);
        end
        default: begin
          state       <= IDLE;
          instr_ready <= 1'b1;
          RegWrite    <= 1'b0;
          done        <= 1'b0;
          br_taken    <= 1'b0;
          br_offset   <= '0;
        end
      endcase
    end
  end

endmodule
